edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of asynchronous input channels (2..8).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer depth per channel (>=2).
REQ-003 The block SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port din, input, N_CH: asynchronous inputs, idle high; a falling edge is one event.
REQ-006 The block SHALL have port evt_valid, output, 1: an event is offered.
REQ-007 The block SHALL have port evt_id, output, ID_W = $clog2(N_CH): channel index of the offered event.
REQ-008 The block SHALL have port evt_ready, input, 1: the consumer accepts when evt_valid & evt_ready at a rising edge.
REQ-009 The block SHALL have port ovr, output, N_CH: sticky per-channel overrun flags.
REQ-010 The block SHALL have port ovr_clr, input, N_CH: per-bit synchronous clear of ovr.
REQ-011 The block SHALL have port evt_cnt, output, 8: count of accepted events, wrapping.
REQ-012 The block SHALL have port busy, output, 1: OR of any pending bit and evt_valid.

Function
REQ-013 Each channel SHALL pass din[i] through SYNC_STAGES flops; a fall pulse is prev_sync & ~sync, lasting one cycle.
REQ-014 A fall pulse SHALL set pending[i] at the next edge.
REQ-015 The FSM SHALL have two states: IDLE and OFFER; evt_valid SHALL be registered and high only in OFFER.
REQ-016 IDLE->OFFER when any pending bit is set: load evt_id with the round-robin winner and clear its pending bit in the same edge.
REQ-017 OFFER->IDLE on evt_valid & evt_ready; otherwise hold OFFER with evt_id stable.
REQ-018 Round-robin search SHALL start at (last_grant+1) mod N_CH; last_grant updates on each IDLE->OFFER.
REQ-019 Latency: din sampled low at edge 0 (SYNC_STAGES=2) SHALL give evt_valid=1 after edge 3, i.e. SYNC_STAGES+1 edges.
REQ-020 Throughput SHALL be at most one event per 2 cycles; with evt_ready tied high, valid pulses last 1 cycle.
REQ-021 A fall pulse while pending[i] is already set SHALL keep pending[i]=1 (one event) and set ovr[i].
REQ-022 A fall pulse in the same cycle the arbiter clears pending[i] SHALL leave pending[i]=1 (new event kept, no overrun).
REQ-023 ovr_clr[i] together with a new overrun on channel i SHALL leave ovr[i]=1 (set wins).
REQ-024 A fall pulse on a channel currently in OFFER SHALL set its pending bit normally; this is not an overrun.
REQ-025 evt_cnt SHALL increment by 1 on each accept and wrap 255->0.
REQ-026 Rising edges of din SHALL produce no event.

Reset
REQ-027 reset SHALL asynchronously force: sync and prev flops=1, pending=0, ovr=0, FSM=IDLE, evt_valid=0, evt_id=0, evt_cnt=0, last_grant=N_CH-1 (channel 0 wins first).
REQ-028 reset asserted in OFFER SHALL drop the offered event with no accept and no count.
REQ-029 din held low across reset release SHALL produce exactly one event per channel.

Structure
REQ-030 Package edge_evt_pkg SHALL hold the default N_CH and SYNC_STAGES, the ID_W function/constant, and the state enum typedef (IDLE, OFFER).
REQ-031 Per-channel synchronizer plus fall detection SHALL be one sub-module, sync_fall_detect, instantiated N_CH times; arbitration, FSM, flags and counter stay in the top module.

Verification
REQ-032 The bench SHALL cover: din[2] falls, evt_ready=1 -> evt_valid after 3 edges with evt_id=2 for 1 cycle, evt_cnt=1.
REQ-033 The bench SHALL cover: din[0], din[1] and din[3] fall in the same cycle, evt_ready=1 -> ids 0,1,3 in order, every other cycle, evt_cnt=3.
REQ-034 The bench SHALL cover: evt_ready=0 for 10 cycles on id 1 -> evt_valid and evt_id stay stable; a second din[1] fall in that window sets pending with ovr[1]=0; a third fall sets ovr[1]=1.
REQ-035 The bench SHALL cover: ovr_clr[1] pulsed in the same cycle as a new overrun on channel 1 -> ovr[1] remains 1; ovr_clr[1] alone -> ovr[1]=0 next cycle.
REQ-036 The bench SHALL cover: reset asserted mid-OFFER -> evt_valid=0 immediately and evt_cnt=0; din[0] held low through release -> exactly one id-0 event.
REQ-037 The bench SHALL cover: 256 accepted events -> evt_cnt wraps to 0.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared constants and types for the edge event arbiter.
//   N_CH_DEF        : default number of asynchronous input channels
//   SYNC_STAGES_DEF : default synchronizer depth per channel
//   ID_W_DEF        : default channel index width
//   id_w()          : index width for a given channel count
//   state_e         : arbiter FSM state (IDLE, OFFER)
package edge_evt_pkg;

  localparam int N_CH_DEF        = 4;
  localparam int SYNC_STAGES_DEF = 2;

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEF = id_w(N_CH_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/edge_event_arbiter_sync_fall_detect.sv
// Single-channel synchronizer with falling-edge detection.
//   clk   : system clock
//   reset : asynchronous active-high reset, forces the chain to idle-high
//   din   : asynchronous input, idle high
//   fall  : one-cycle pulse when the synchronized input goes high->low
module sync_fall_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: turns falling edges on N_CH asynchronous inputs into
// a stream of channel-id events offered through a valid/ready handshake,
// served round-robin.
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   din       : asynchronous inputs, idle high; a falling edge is one event
//   evt_valid : an event is offered (registered)
//   evt_id    : channel index of the offered event
//   evt_ready : consumer accepts on evt_valid & evt_ready at a rising edge
//   ovr       : sticky per-channel overrun flags
//   ovr_clr   : per-bit synchronous clear of ovr (a new overrun wins)
//   evt_cnt   : wrapping count of accepted events
//   busy      : any event pending or offered
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int ID_W       = id_w(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] din,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready,
  output logic [N_CH-1:0] ovr,
  input  logic [N_CH-1:0] ovr_clr,
  output logic [7:0]      evt_cnt,
  output logic            busy
);

  logic [N_CH-1:0] fall;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sync_fall_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (din[i]),
      .fall  (fall[i])
    );
  end

  state_e          state_q, state_d;
  logic            evt_valid_q, evt_valid_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] ovr_q, ovr_d;
  logic [7:0]      evt_cnt_q, evt_cnt_d;

  logic            found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand;
  int unsigned     idx;
  logic [N_CH-1:0] clr_mask;
  logic [N_CH-1:0] overrun;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx  = (32'(last_grant_q) + 32'd1 + k) % 32'(N_CH);
      cand = ID_W'(idx);
      if (!found && pending_q[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    evt_cnt_d    = evt_cnt_q;
    clr_mask     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = OFFER;
          evt_id_d     = win_id;
          last_grant_d = win_id;
          clr_mask     = N_CH'(1) << win_id;
        end
      end
      OFFER: begin
        if (evt_valid_q && evt_ready) begin
          state_d   = IDLE;
          evt_cnt_d = evt_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    evt_valid_d = (state_d == OFFER);

    // A fall arriving while the arbiter clears the same bit is a fresh event,
    // so it re-sets pending and is not counted as an overrun.
    overrun   = fall & pending_q & ~clr_mask;
    pending_d = (pending_q & ~clr_mask) | fall;
    ovr_d     = (ovr_q & ~ovr_clr) | overrun;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      last_grant_q <= ID_W'(N_CH - 1);
      pending_q    <= '0;
      ovr_q        <= '0;
      evt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      ovr_q        <= ovr_d;
      evt_cnt_q    <= evt_cnt_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign ovr       = ovr_q;
  assign evt_cnt   = evt_cnt_q;
  assign busy      = (|pending_q) | evt_valid_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] din;
  logic          evt_valid;
  logic [1:0]    evt_id;
  logic          evt_ready;
  logic [NC-1:0] ovr;
  logic [NC-1:0] ovr_clr;
  logic [7:0]    evt_cnt;
  logic          busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_q[$];
  int unsigned unstable;

  typedef struct {
    logic [NC-1:0] mask;
    int unsigned   n_evt;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  edge_event_arbiter #(.N_CH(NC), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr),
    .evt_cnt   (evt_cnt),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    exp_q.delete();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic hold_check(input int unsigned n, input logic [1:0] id);
    repeat (n) begin
      tick(1);
      if (!(evt_valid === 1'b1 && evt_id === id)) unstable++;
    end
  endtask

  // Scoreboard: every accepted event is compared against the oldest expected id.
  always @(negedge clk) begin
    if (reset === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt", 32'(evt_id), 32'hFFFF_FFFF);
      end else begin
        check("evt_id_sb", 32'(evt_id), exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] vbits, expbits;

    vecs[0] = '{mask: 4'b1011, n_evt: 3};
    vecs[1] = '{mask: 4'b0110, n_evt: 2};
    vecs[2] = '{mask: 4'b1111, n_evt: 4};
    vecs[3] = '{mask: 4'b1000, n_evt: 1};
    vecs[4] = '{mask: 4'b0000, n_evt: 0};

    reset     = 1'b1;
    din       = '1;
    evt_ready = 1'b1;
    ovr_clr   = '0;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("rst_valid", 32'(evt_valid), 0);
    check("rst_id",    32'(evt_id),    0);
    check("rst_cnt",   32'(evt_cnt),   0);
    check("rst_ovr",   32'(ovr),       0);
    check("rst_busy",  32'(busy),      0);

    // Single event latency on channel 2.
    reset_dut();
    din[2] = 1'b0;
    exp_q.push_back(2);
    tick(3);
    check("lat_e2_valid", 32'(evt_valid), 0);
    check("lat_e2_busy",  32'(busy),      1);
    tick(1);
    check("lat_e3_valid", 32'(evt_valid), 1);
    check("lat_e3_id",    32'(evt_id),    2);
    tick(1);
    check("valid_one_cycle", 32'(evt_valid), 0);
    check("lat_cnt", 32'(evt_cnt), 1);
    din[2] = 1'b1;
    tick(4);
    check("lat_busy_idle", 32'(busy), 0);
    check("no_rise_evt", 32'(evt_cnt), 1);

    // Simultaneous falls from reset: ascending order, one valid every other cycle.
    for (int unsigned v = 0; v < 5; v++) begin
      reset_dut();
      for (int unsigned c = 0; c < NC; c++)
        if (vecs[v].mask[c]) exp_q.push_back(c);
      din     = ~vecs[v].mask;
      vbits   = '0;
      expbits = '0;
      for (int unsigned m = 0; m < vecs[v].n_evt; m++) expbits[4 + 2*m] = 1'b1;
      for (int unsigned j = 1; j < 16; j++) begin
        tick(1);
        vbits[j] = evt_valid;
      end
      check($sformatf("vec%0d_pattern", v), 32'(vbits), 32'(expbits));
      check($sformatf("vec%0d_cnt", v), 32'(evt_cnt), vecs[v].n_evt);
      check($sformatf("vec%0d_sb_empty", v), exp_q.size(), 0);
      din = '1;
      tick(3);
    end

    // Round-robin resumes after the last grant.
    reset_dut();
    din[2] = 1'b0;
    exp_q.push_back(2);
    tick(8);
    din[2] = 1'b1;
    tick(4);
    din = '0;
    exp_q.push_back(3);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    tick(14);
    din = '1;
    tick(4);
    check("rr_cnt", 32'(evt_cnt), 5);
    check("rr_sb_empty", exp_q.size(), 0);

    // Back-pressure on id 1, refall while offered, then overrun.
    reset_dut();
    evt_ready = 1'b0;
    din[1] = 1'b0;
    exp_q.push_back(1);
    tick(4);
    check("bp_valid", 32'(evt_valid), 1);
    check("bp_id",    32'(evt_id),    1);
    unstable = 0;
    hold_check(2, 2'd1);
    din[1] = 1'b1;
    hold_check(3, 2'd1);
    din[1] = 1'b0;
    exp_q.push_back(1);
    hold_check(4, 2'd1);
    check("bp_ovr_2nd", 32'(ovr), 0);
    din[1] = 1'b1;
    hold_check(3, 2'd1);
    din[1] = 1'b0;
    hold_check(4, 2'd1);
    check("bp_ovr_3rd", 32'(ovr), 32'h2);
    check("bp_stable", unstable, 0);
    evt_ready = 1'b1;
    tick(6);
    check("bp_cnt", 32'(evt_cnt), 2);
    check("bp_sb_empty", exp_q.size(), 0);

    // ovr_clr alone clears; ovr_clr with a new overrun leaves the flag set.
    evt_ready = 1'b0;
    ovr_clr = 4'b0010;
    tick(1);
    ovr_clr = '0;
    check("ovr_clr_first", 32'(ovr), 0);
    din[1] = 1'b1;
    tick(3);
    din[1] = 1'b0;
    exp_q.push_back(1);
    tick(5);
    din[1] = 1'b1;
    tick(3);
    din[1] = 1'b0;
    exp_q.push_back(1);
    tick(5);
    check("ovr_pre_set", 32'(ovr), 0);
    din[1] = 1'b1;
    tick(3);
    din[1] = 1'b0;
    tick(2);
    ovr_clr = 4'b0010;
    tick(1);
    ovr_clr = '0;
    check("ovr_set_wins", 32'(ovr), 32'h2);
    tick(2);
    ovr_clr = 4'b0010;
    tick(1);
    ovr_clr = '0;
    check("ovr_clr_alone", 32'(ovr), 0);
    din[1] = 1'b1;
    evt_ready = 1'b1;
    tick(6);
    check("ovr_cnt", 32'(evt_cnt), 4);
    check("ovr_sb_empty", exp_q.size(), 0);

    // Reset asserted mid-offer, din[0] held low through release.
    evt_ready = 1'b0;
    din[0] = 1'b0;
    tick(4);
    check("pre_rst_valid", 32'(evt_valid), 1);
    check("pre_rst_id",    32'(evt_id),    0);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid_drop", 32'(evt_valid), 0);
    check("async_cnt_clear",  32'(evt_cnt),   0);
    tick(2);
    reset = 1'b0;
    evt_ready = 1'b1;
    exp_q.push_back(0);
    tick(8);
    check("rel_one_evt", 32'(evt_cnt), 1);
    check("rel_sb_empty", exp_q.size(), 0);
    din[0] = 1'b1;
    tick(4);
    check("rel_no_extra", 32'(evt_cnt), 1);

    // Counter wrap after 256 accepts in total.
    for (int unsigned i = 0; i < 254; i++) begin
      din[i % NC] = 1'b0;
      exp_q.push_back(i % NC);
      tick(3);
      din[i % NC] = 1'b1;
      tick(3);
    end
    tick(4);
    check("cnt_255", 32'(evt_cnt), 255);
    din[2] = 1'b0;
    exp_q.push_back(2);
    tick(3);
    din[2] = 1'b1;
    tick(6);
    check("cnt_wrap", 32'(evt_cnt), 0);
    check("final_sb_empty", exp_q.size(), 0);
    check("final_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
